// File: rtl/seg7_pkg.sv
// Shared constants for the Wishbone seven-segment display slave:
// register addresses, CTRL field positions and reset value, and the
// active-high hex-to-segment table ({g,f,e,d,c,b,a}).
package seg7_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_DP_LSB   = 8;
  localparam int CTRL_MASK_LSB = 16;

  localparam logic [31:0] CTRL_RST = 32'h00FF_0001;

  // Entry n is the lit-segment pattern for hex digit n (entry 15 is leftmost).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to 7-segment decoder, active-high output
// ({g,f,e,d,c,b,a}). Pin polarity is handled by the instantiating block.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/wb_seg7_slave.sv
// Wishbone classic slave driving an 8-digit multiplexed seven-segment display.
// Registers: CTRL (enable, decimal points, digit mask), DATA (8 hex nibbles),
// DIV (clocks per digit), STATUS (digit index, frame count).
// Optional feature macro SEG7_DP_EN: when defined, CTRL[15:8] holds per-digit
// decimal points; otherwise those bits read 0 and dp is never lit.
module wb_seg7_slave
  import seg7_pkg::*;
#(
  parameter logic [23:0] SCAN_DIV_RST   = 24'd50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_an
);

  localparam logic [7:0] PIN_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic        bus_req;
  logic        wr_en;
  logic        ctrl_en;
  logic [7:0]  ctrl_mask;
  logic [7:0]  ctrl_dp;
  logic [31:0] data_q;
  logic [23:0] div_q;
  logic [23:0] div_cnt;
  logic [2:0]  digit_idx;
  logic [7:0]  frame_cnt;
  logic [31:0] data_wr;
  logic [23:0] div_wr;
  logic [31:0] rd_data;
  logic [3:0]  nibble;
  logic [6:0]  hex_seg;
  logic [7:0]  seg_act;
  logic [7:0]  an_act;

  // A new request is one not already being acknowledged this cycle.
  assign bus_req = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr_en   = bus_req & i_wb_we;

  // Byte-lane merge of write data into DATA and DIV.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    data_wr = data_q;
    div_wr  = div_q;
    for (int b = 0; b < 4; b++)
      if (i_wb_sel[b]) data_wr[8*b +: 8] = i_wb_data[8*b +: 8];
    for (int b = 0; b < 3; b++)
      if (i_wb_sel[b]) div_wr[8*b +: 8] = i_wb_data[8*b +: 8];
  end

  // Read mux for the addressed register.
  always_comb begin
    rd_data = '0;
    case (i_wb_addr)
      ADDR_CTRL:   rd_data = {8'h00, ctrl_mask, ctrl_dp, 7'h00, ctrl_en};
      ADDR_DATA:   rd_data = data_q;
      ADDR_DIV:    rd_data = {8'h00, div_q};
      ADDR_STATUS: rd_data = {16'h0000, frame_cnt, 5'h00, digit_idx};
    endcase
  end

  // Bus handshake: single-cycle ack, read data captured on the ack edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      o_wb_ack  <= bus_req;
      o_wb_data <= (bus_req & ~i_wb_we) ? rd_data : 32'h0;
    end
  end

  // Register writes commit on the edge that raises ack; STATUS is read-only.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl_en   <= CTRL_RST[CTRL_EN_BIT];
      ctrl_mask <= CTRL_RST[CTRL_MASK_LSB +: 8];
      data_q    <= '0;
      div_q     <= SCAN_DIV_RST;
    end else if (wr_en) begin
      case (i_wb_addr)
        ADDR_CTRL: begin
          if (i_wb_sel[0]) ctrl_en   <= i_wb_data[CTRL_EN_BIT];
          if (i_wb_sel[2]) ctrl_mask <= i_wb_data[CTRL_MASK_LSB +: 8];
        end
        ADDR_DATA: data_q <= data_wr;
        ADDR_DIV:  div_q  <= (div_wr == 24'd0) ? 24'd1 : div_wr;
        default: ;
      endcase
    end
  end

`ifdef SEG7_DP_EN
  // Per-digit decimal point bits in CTRL byte 1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      ctrl_dp <= CTRL_RST[CTRL_DP_LSB +: 8];
    else if (wr_en && i_wb_addr == ADDR_CTRL && i_wb_sel[1])
      ctrl_dp <= i_wb_data[CTRL_DP_LSB +: 8];
  end
`else
  assign ctrl_dp = 8'h00;
`endif

  // Scan engine: dwell DIV clocks per digit, count completed 8-digit frames.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
    end else if (!ctrl_en) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_cnt >= div_q - 24'd1) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 3'd1;
      if (digit_idx == 3'd7) frame_cnt <= frame_cnt + 8'd1;
    end else begin
      div_cnt <= div_cnt + 24'd1;
    end
  end

  assign nibble = data_q[{digit_idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .hex (nibble),
    .seg (hex_seg)
  );

  // Active-high view of the current digit; everything dark while disabled.
  always_comb begin
    seg_act = 8'h00;
    an_act  = 8'h00;
    if (ctrl_en) begin
      seg_act = {ctrl_dp[digit_idx], hex_seg};
      an_act  = ctrl_mask[digit_idx] ? (8'b1 << digit_idx) : 8'h00;
    end
  end

  // Registered pins with board polarity applied.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_seg <= PIN_IDLE;
      o_an  <= PIN_IDLE;
    end else begin
      o_seg <= SEG_ACTIVE_LOW ? ~seg_act : seg_act;
      o_an  <= SEG_ACTIVE_LOW ? ~an_act  : an_act;
    end
  end

endmodule

// File: tb/tb_wb_seg7_slave.sv
// Scoreboard bench for wb_seg7_slave: bus transfers push expected read
// data, a negedge monitor pops and compares on every ack. Pin behaviour is
// checked directly against hand-computed patterns.
module tb_wb_seg7_slave;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [1:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic [7:0]  o_seg, o_an;

  always #5 i_clk = ~i_clk;

  wb_seg7_slave #(
    .SCAN_DIV_RST   (24'd50000),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wb_cyc  (i_wb_cyc),
    .i_wb_stb  (i_wb_stb),
    .i_wb_we   (i_wb_we),
    .i_wb_sel  (i_wb_sel),
    .i_wb_addr (i_wb_addr),
    .i_wb_data (i_wb_data),
    .o_wb_ack  (o_wb_ack),
    .o_wb_data (o_wb_data),
    .o_seg     (o_seg),
    .o_an      (o_an)
  );

  // Active-high segment patterns for hex 0..F, written out by hand.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; acks must be one cycle wide.
  logic prev_ack = 1'b0;
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_reset_n) begin
      prev_ack = 1'b0;
    end else begin
      if (o_wb_ack) begin
        check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with no transfer pending, expected none");
        end else begin
          e = sb_q.pop_front();
          if (e.is_read) check(e.name, o_wb_data & e.mask, e.exp & e.mask);
        end
      end
      prev_ack = o_wb_ack;
    end
  end

  task automatic xfer(input bit w, input logic [1:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] exp,
                      input logic [31:0] msk, input string name, input bit hold);
    exp_t e;
    int   n;
    e.is_read = !w;
    e.exp     = exp;
    e.mask    = msk;
    e.name    = name;
    sb_q.push_back(e);
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = w;
    i_wb_addr = a; i_wb_sel = s; i_wb_data = d;
    n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (!o_wb_ack && n < 8);
    check({name, "_ack_latency"}, n, 1);
    if (hold) begin
      @(posedge i_clk); #1;
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                    input string name);
    xfer(1'b1, a, s, d, 32'h0, 32'h0, name, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    xfer(1'b0, a, 4'hF, 32'h0, exp, 32'hFFFF_FFFF, name, 1'b0);
  endtask

  task automatic wait_an(input logic [7:0] target, input int budget, input string name);
    int n = 0;
    while (o_an !== target && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_an_seen"}, {24'd0, o_an}, {24'd0, target});
  endtask

  bit          dp_en;
  logic [7:0]  exp_an;
  logic [7:0]  exp_seg;
  bit          odd_lit;
  bit          d0_seen;

  initial begin
`ifdef SEG7_DP_EN
    dp_en = 1'b1;
`else
    dp_en = 1'b0;
`endif
    i_reset_n = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_sel = 4'h0; i_wb_addr = 2'd0; i_wb_data = 32'h0;

    // Reset state on the pins and registers.
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ack",  {31'd0, o_wb_ack}, 32'd0);
    check("rst_rdata", o_wb_data, 32'h0);
    check("rst_an",   {24'd0, o_an},  32'h0000_00FF);
    check("rst_seg",  {24'd0, o_seg}, 32'h0000_00FF);
    i_reset_n = 1'b1;
    rd(2'd0, 32'h00FF_0001, "rst_ctrl");
    rd(2'd1, 32'h0000_0000, "rst_data");
    rd(2'd2, 32'd50000,     "rst_div");
    rd(2'd3, 32'h0000_0000, "rst_status");
    @(negedge i_clk);
    check("rst_scan_an",  {24'd0, o_an},  32'h0000_00FE);
    check("rst_scan_seg", {24'd0, o_seg}, 32'h0000_00C0);

    // Digit walk with DIV = 4; DATA write holds strobe through the ack cycle.
    xfer(1'b1, 2'd1, 4'hF, 32'h7654_3210, 32'h0, 32'h0, "wr_data_hold", 1'b1);
    wr(2'd2, 4'hF, 32'd4, "wr_div4");
    rd(2'd2, 32'd4, "rd_div4");
    rd(2'd1, 32'h7654_3210, "rd_data");
    wait_an(8'hFE, 80, "walk_d0");
    wait_an(8'hFD, 80, "walk_d1");
    check("walk_seg1", {24'd0, o_seg}, 32'h0000_00F9);
    for (int k = 2; k < 9; k++) begin
      repeat (4) @(negedge i_clk);
      exp_an  = ~(8'b1 << (k % 8));
      exp_seg = ~{1'b0, hex_tab[k % 8]};
      check($sformatf("walk_an%0d", k % 8),  {24'd0, o_an},  {24'd0, exp_an});
      check($sformatf("walk_seg%0d", k % 8), {24'd0, o_seg}, {24'd0, exp_seg});
    end

    // Digit mask via byte lane 2 only; enable must survive.
    wr(2'd0, 4'b0100, 32'h0055_0000, "wr_mask");
    rd(2'd0, 32'h0055_0001, "rd_mask");
    odd_lit = 1'b0;
    d0_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge i_clk);
      if ((~o_an & 8'hAA) != 8'h00) odd_lit = 1'b1;
      if (o_an == 8'hFE) d0_seen = 1'b1;
    end
    check("mask_odd_dark", {31'd0, odd_lit}, 32'd0);
    check("mask_d0_lit",   {31'd0, d0_seen}, 32'd1);
    wr(2'd0, 4'b0000, 32'h0000_0000, "wr_sel0");
    rd(2'd0, 32'h0055_0001, "rd_sel0");
    wr(2'd3, 4'hF, 32'hFFFF_FFFF, "wr_status");
    xfer(1'b0, 2'd3, 4'hF, 32'h0, 32'h0, 32'hFFFF_00F8, "rd_status_rsvd", 1'b0);

    // Decimal point for digit 0 (DATA digit 0 is 0, digit 2 is 2).
    wr(2'd0, 4'b0010, 32'h0000_0100, "wr_dp");
    rd(2'd0, dp_en ? 32'h0055_0101 : 32'h0055_0001, "rd_dp");
    wait_an(8'hFE, 80, "dp_d0");
    check("dp_seg0", {24'd0, o_seg}, dp_en ? 32'h0000_0040 : 32'h0000_00C0);
    wait_an(8'hFB, 80, "dp_d2");
    check("dp_seg2", {24'd0, o_seg}, 32'h0000_00A4);

    // Reset asserted during an ack cycle.
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = 2'd1; i_wb_sel = 4'hF; i_wb_data = 32'hDEAD_BEEF;
    @(posedge i_clk); #1;
    check("rstack_ack_high", {31'd0, o_wb_ack}, 32'd1);
    #1 i_reset_n = 1'b0;
    #1;
    check("rstack_ack_drop", {31'd0, o_wb_ack}, 32'd0);
    check("rstack_an",       {24'd0, o_an},     32'h0000_00FF);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    rd(2'd1, 32'h0000_0000, "rstack_data");
    rd(2'd0, 32'h00FF_0001, "rstack_ctrl");

    // DIV = 0 is stored as 1: index advances every clock, frame every 8.
    wr(2'd2, 4'hF, 32'h0, "wr_div0");
    rd(2'd2, 32'd1, "rd_div0");
    rd(2'd3, 32'h0000_0003, "div1_status_a");
    repeat (10) @(posedge i_clk);
    rd(2'd3, 32'h0000_0107, "div1_status_b");
    rd(2'd3, 32'h0000_0201, "div1_status_c");

    // Disable mid-scan, then re-enable from digit 0.
    wr(2'd0, 4'hF, 32'h0000_0000, "wr_disable");
    repeat (2) @(negedge i_clk);
    check("dis_an",  {24'd0, o_an},  32'h0000_00FF);
    check("dis_seg", {24'd0, o_seg}, 32'h0000_00FF);
    xfer(1'b0, 2'd3, 4'hF, 32'h0, 32'h0, 32'h0000_0007, "dis_status_idx", 1'b0);
    wr(2'd0, 4'hF, 32'h00FF_0001, "wr_enable");
    @(negedge i_clk);
    check("en_an_idle", {24'd0, o_an}, 32'h0000_00FF);
    @(negedge i_clk);
    check("en_an_d0",  {24'd0, o_an},  32'h0000_00FE);
    check("en_seg_d0", {24'd0, o_seg}, 32'h0000_00C0);
    @(negedge i_clk);
    check("en_an_d1", {24'd0, o_an}, 32'h0000_00FD);

    repeat (4) @(posedge i_clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
